// File: rtl/dma_desc_mc.sv
// rtl/dma_desc_mc.sv - multi-channel DMA descriptor block with round-robin issue
module dma_desc_mc #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_dmaen,
    input  logic              i_desc_we,
    input  logic [CH_W-1:0]   i_desc_ch,
    input  logic [3:0]        i_desc_sel,
    input  logic [DATA_W-1:0] i_desc_wdata,
    output logic              o_issue_valid,
    input  logic              i_issue_ready,
    output logic [CH_W-1:0]   o_issue_ch,
    output logic [ADDR_W-1:0] o_issue_src,
    output logic [ADDR_W-1:0] o_issue_dst,
    output logic [DATA_W-1:0] o_issue_len,
    input  logic              i_done,
    input  logic [CH_W-1:0]   i_done_ch,
    output logic              o_next_valid,
    output logic [CH_W-1:0]   o_next_ch,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic [NUM_CH-1:0] o_ch_busy,
    output logic [NUM_CH-1:0] o_irq,
    input  logic [NUM_CH-1:0] i_irq_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACTIVE} ch_state_t;

    localparam logic [3:0] SEL_SRC    = 4'd0;
    localparam logic [3:0] SEL_DST    = 4'd1;
    localparam logic [3:0] SEL_LEN    = 4'd2;
    localparam logic [3:0] SEL_NEXT   = 4'd3;
    localparam logic [3:0] SEL_EOC    = 4'd4;
    localparam logic [3:0] SEL_COMMIT = 4'd5;

    ch_state_t         r_state     [NUM_CH];
    ch_state_t         w_state_nxt [NUM_CH];
    logic [ADDR_W-1:0] r_src       [NUM_CH];
    logic [ADDR_W-1:0] r_dst       [NUM_CH];
    logic [ADDR_W-1:0] r_next      [NUM_CH];
    logic [DATA_W-1:0] r_len       [NUM_CH];
    logic [NUM_CH-1:0] r_eoc;

    logic              r_issue_valid;
    logic [CH_W-1:0]   r_issue_ch;
    logic [ADDR_W-1:0] r_issue_src;
    logic [ADDR_W-1:0] r_issue_dst;
    logic [DATA_W-1:0] r_issue_len;
    logic [CH_W-1:0]   r_ptr;
    logic              r_next_valid;
    logic [CH_W-1:0]   r_next_ch;
    logic [ADDR_W-1:0] r_next_addr;
    logic [NUM_CH-1:0] r_ch_busy;
    logic [NUM_CH-1:0] r_irq;

    logic              w_hs;
    logic              w_commit;
    logic              w_commit_zero;
    logic              w_done_hit;
    logic [NUM_CH-1:0] w_irq_set;
    logic              w_next_fire;
    logic [CH_W-1:0]   w_next_ch;
    logic [ADDR_W-1:0] w_next_addr;
    logic [NUM_CH-1:0] w_eligible;
    logic              w_found;
    logic [CH_W-1:0]   w_pick;
    logic [CH_W-1:0]   w_idx;

    always_comb begin
        w_hs          = r_issue_valid && i_issue_ready;
        w_commit      = i_desc_we && (i_desc_sel == SEL_COMMIT) &&
                        (r_state[i_desc_ch] == ST_IDLE) && i_dmaen[i_desc_ch];
        w_commit_zero = w_commit && (r_len[i_desc_ch] == '0);
        w_done_hit    = i_done && (r_state[i_done_ch] == ST_ACTIVE);

        w_irq_set = '0;
        if (w_done_hit && r_eoc[i_done_ch])
            w_irq_set[i_done_ch] = 1'b1;
        if (w_commit_zero && r_eoc[i_desc_ch])
            w_irq_set[i_desc_ch] = 1'b1;

        // Engine completion takes the single chain slot over a zero-length commit.
        w_next_fire = 1'b0;
        w_next_ch   = r_next_ch;
        w_next_addr = r_next_addr;
        if (w_done_hit && !r_eoc[i_done_ch]) begin
            w_next_fire = 1'b1;
            w_next_ch   = i_done_ch;
            w_next_addr = r_next[i_done_ch];
        end else if (w_commit_zero && !r_eoc[i_desc_ch]) begin
            w_next_fire = 1'b1;
            w_next_ch   = i_desc_ch;
            w_next_addr = r_next[i_desc_ch];
        end

        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_eligible[i]  = (r_state[i] == ST_PEND) && i_dmaen[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_commit && !w_commit_zero && (i_desc_ch == CH_W'(i)))
                        w_state_nxt[i] = ST_PEND;
                end
                ST_PEND: begin
                    if (w_hs && (r_issue_ch == CH_W'(i)))
                        w_state_nxt[i] = ST_ACTIVE;
                    else if (!i_dmaen[i])
                        w_state_nxt[i] = ST_IDLE;
                end
                ST_ACTIVE: begin
                    if (w_done_hit && (i_done_ch == CH_W'(i)))
                        w_state_nxt[i] = ST_IDLE;
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end

        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = r_ptr + CH_W'(k);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_src[i]  <= '0;
                r_dst[i]  <= '0;
                r_next[i] <= '0;
                r_len[i]  <= '0;
            end
            r_eoc <= '0;
        end else if (i_desc_we && (r_state[i_desc_ch] == ST_IDLE)) begin
            case (i_desc_sel)
                SEL_SRC:  r_src[i_desc_ch]  <= i_desc_wdata[ADDR_W-1:0];
                SEL_DST:  r_dst[i_desc_ch]  <= i_desc_wdata[ADDR_W-1:0];
                SEL_LEN:  r_len[i_desc_ch]  <= i_desc_wdata;
                SEL_NEXT: r_next[i_desc_ch] <= i_desc_wdata[ADDR_W-1:0];
                SEL_EOC:  r_eoc[i_desc_ch]  <= i_desc_wdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_CH; i++)
                r_state[i] <= ST_IDLE;
            r_ch_busy     <= '0;
            r_irq         <= '0;
            r_next_valid  <= 1'b0;
            r_next_ch     <= '0;
            r_next_addr   <= '0;
            r_issue_valid <= 1'b0;
            r_issue_ch    <= '0;
            r_issue_src   <= '0;
            r_issue_dst   <= '0;
            r_issue_len   <= '0;
            r_ptr         <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= w_state_nxt[i];
                r_ch_busy[i] <= (w_state_nxt[i] != ST_IDLE);
            end
            r_irq        <= (r_irq & ~i_irq_clr) | w_irq_set;
            r_next_valid <= w_next_fire;
            r_next_ch    <= w_next_ch;
            r_next_addr  <= w_next_addr;

            // An open offer closes on handshake or cancel; a new grant only starts from idle,
            // which yields the single bubble between consecutive grants.
            if (r_issue_valid) begin
                if (w_hs) begin
                    r_issue_valid <= 1'b0;
                    r_ptr         <= r_issue_ch + 1'b1;
                end else if (!i_dmaen[r_issue_ch]) begin
                    r_issue_valid <= 1'b0;
                end
            end else if (w_found) begin
                r_issue_valid <= 1'b1;
                r_issue_ch    <= w_pick;
                r_issue_src   <= r_src[w_pick];
                r_issue_dst   <= r_dst[w_pick];
                r_issue_len   <= r_len[w_pick];
            end
        end
    end

    assign o_issue_valid = r_issue_valid;
    assign o_issue_ch    = r_issue_ch;
    assign o_issue_src   = r_issue_src;
    assign o_issue_dst   = r_issue_dst;
    assign o_issue_len   = r_issue_len;
    assign o_next_valid  = r_next_valid;
    assign o_next_ch     = r_next_ch;
    assign o_next_addr   = r_next_addr;
    assign o_ch_busy     = r_ch_busy;
    assign o_irq         = r_irq;

endmodule

// File: tb/tb_dma_desc_mc.sv
// tb/tb_dma_desc_mc.sv - randomized and directed bench for dma_desc_mc against a behavioural model
module tb_dma_desc_mc;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CH_W   = 2;
    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_ACT  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] dmaen = '0;
    logic              desc_we = 1'b0;
    logic [CH_W-1:0]   desc_ch = '0;
    logic [3:0]        desc_sel = '0;
    logic [DATA_W-1:0] desc_wdata = '0;
    logic              issue_ready = 1'b0;
    logic              done = 1'b0;
    logic [CH_W-1:0]   done_ch = '0;
    logic [NUM_CH-1:0] irq_clr = '0;
    logic              o_issue_valid;
    logic [CH_W-1:0]   o_issue_ch;
    logic [ADDR_W-1:0] o_issue_src;
    logic [ADDR_W-1:0] o_issue_dst;
    logic [DATA_W-1:0] o_issue_len;
    logic              o_next_valid;
    logic [CH_W-1:0]   o_next_ch;
    logic [ADDR_W-1:0] o_next_addr;
    logic [NUM_CH-1:0] o_ch_busy;
    logic [NUM_CH-1:0] o_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dma_desc_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_dmaen(dmaen),
        .i_desc_we(desc_we), .i_desc_ch(desc_ch), .i_desc_sel(desc_sel), .i_desc_wdata(desc_wdata),
        .o_issue_valid(o_issue_valid), .i_issue_ready(issue_ready), .o_issue_ch(o_issue_ch),
        .o_issue_src(o_issue_src), .o_issue_dst(o_issue_dst), .o_issue_len(o_issue_len),
        .i_done(done), .i_done_ch(done_ch),
        .o_next_valid(o_next_valid), .o_next_ch(o_next_ch), .o_next_addr(o_next_addr),
        .o_ch_busy(o_ch_busy), .o_irq(o_irq), .i_irq_clr(irq_clr)
    );

    // Reference model: per-channel life cycle, descriptor table, one open offer.
    int          m_st   [NUM_CH];
    logic [31:0] m_src  [NUM_CH];
    logic [31:0] m_dst  [NUM_CH];
    logic [31:0] m_len  [NUM_CH];
    logic [31:0] m_nxt  [NUM_CH];
    bit          m_eoc  [NUM_CH];
    bit          m_ov;
    int          m_och;
    logic [31:0] m_osrc, m_odst, m_olen;
    int          m_ptr;
    logic [3:0]  m_irq;
    bit          m_nv;
    int          m_nch;
    logic [31:0] m_naddr;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = M_IDLE; m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_nxt[c] = 0; m_eoc[c] = 0;
        end
        m_ov = 0; m_och = 0; m_osrc = 0; m_odst = 0; m_olen = 0;
        m_ptr = 0; m_irq = 0; m_nv = 0; m_nch = 0; m_naddr = 0;
    endtask

    task automatic model_step();
        int st_new [NUM_CH];
        logic [3:0] set;
        bit hs, done_hit, commit, zero;
        int pick, c;
        hs       = m_ov && issue_ready;
        done_hit = done && (m_st[done_ch] == M_ACT);
        commit   = desc_we && (desc_sel == 4'd5) && (m_st[desc_ch] == M_IDLE) && dmaen[desc_ch];
        zero     = commit && (m_len[desc_ch] == 0);
        set  = 0;
        m_nv = 0;
        if (done_hit) begin
            if (m_eoc[done_ch]) set[done_ch] = 1'b1;
            else begin m_nv = 1; m_nch = int'(done_ch); m_naddr = m_nxt[done_ch]; end
        end
        if (zero) begin
            if (m_eoc[desc_ch]) set[desc_ch] = 1'b1;
            else if (!m_nv) begin m_nv = 1; m_nch = int'(desc_ch); m_naddr = m_nxt[desc_ch]; end
        end
        pick = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (m_ptr + k) % NUM_CH;
            if (pick < 0 && m_st[c] == M_PEND && dmaen[c]) pick = c;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            st_new[i] = m_st[i];
            if (m_st[i] == M_IDLE && commit && !zero && int'(desc_ch) == i) st_new[i] = M_PEND;
            else if (m_st[i] == M_PEND && hs && m_och == i) st_new[i] = M_ACT;
            else if (m_st[i] == M_PEND && !dmaen[i]) st_new[i] = M_IDLE;
            else if (m_st[i] == M_ACT && done_hit && int'(done_ch) == i) st_new[i] = M_IDLE;
        end
        if (m_ov) begin
            if (hs) begin m_ov = 0; m_ptr = (m_och + 1) % NUM_CH; end
            else if (!dmaen[m_och]) m_ov = 0;
        end else if (pick >= 0) begin
            m_ov = 1; m_och = pick; m_osrc = m_src[pick]; m_odst = m_dst[pick]; m_olen = m_len[pick];
        end
        if (desc_we && m_st[desc_ch] == M_IDLE) begin
            case (desc_sel)
                4'd0: m_src[desc_ch] = desc_wdata;
                4'd1: m_dst[desc_ch] = desc_wdata;
                4'd2: m_len[desc_ch] = desc_wdata;
                4'd3: m_nxt[desc_ch] = desc_wdata;
                4'd4: m_eoc[desc_ch] = desc_wdata[0];
                default: ;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) m_st[i] = st_new[i];
        m_irq = (m_irq & ~irq_clr) | set;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] eb;
        for (int c = 0; c < NUM_CH; c++) eb[c] = (m_st[c] != M_IDLE);
        chk("issue_valid", 32'(o_issue_valid), 32'(m_ov));
        if (m_ov) begin
            chk("issue_ch", 32'(o_issue_ch), 32'(m_och));
            chk("issue_src", o_issue_src, m_osrc);
            chk("issue_dst", o_issue_dst, m_odst);
            chk("issue_len", o_issue_len, m_olen);
        end
        chk("next_valid", 32'(o_next_valid), 32'(m_nv));
        if (m_nv) begin
            chk("next_ch", 32'(o_next_ch), 32'(m_nch));
            chk("next_addr", o_next_addr, m_naddr);
        end
        chk("ch_busy", 32'(o_ch_busy), 32'(eb));
        chk("irq", 32'(o_irq), 32'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int ch, input int sel, input logic [31:0] d);
        desc_we = 1'b1; desc_ch = 2'(ch); desc_sel = 4'(sel); desc_wdata = d;
        cycle();
        desc_we = 1'b0;
    endtask

    task automatic pulse_done(input int ch);
        done = 1'b1; done_ch = 2'(ch);
        cycle();
        done = 1'b0;
    endtask

    task automatic collect_grants(input int n, output int order[$], output int when[$]);
        order = {};
        when  = {};
        for (int t = 0; t < n; t++) begin
            if (o_issue_valid && issue_ready) begin
                order.push_back(int'(o_issue_ch));
                when.push_back(t);
            end
            cycle();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int when[$];
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_issue_valid", 32'(o_issue_valid), 32'd0);
        chk("reset_busy", 32'(o_ch_busy), 32'd0);
        rst_n = 1'b1;
        dmaen = 4'hF;

        // Single descriptor with EOC: issue then irq.
        issue_ready = 1'b1;
        wr(1, 0, 32'h1000); wr(1, 1, 32'h2000); wr(1, 2, 32'h40); wr(1, 4, 32'h1); wr(1, 5, 32'h0);
        chk("t1_busy_after_commit", 32'(o_ch_busy), 32'h2);
        chk("t1_no_offer_yet", 32'(o_issue_valid), 32'd0);
        cycle();
        chk("t1_valid", 32'(o_issue_valid), 32'd1);
        chk("t1_ch", 32'(o_issue_ch), 32'd1);
        chk("t1_src", o_issue_src, 32'h1000);
        chk("t1_dst", o_issue_dst, 32'h2000);
        chk("t1_len", o_issue_len, 32'h40);
        cycle();
        chk("t1_bubble", 32'(o_issue_valid), 32'd0);
        idle(2);
        pulse_done(1);
        chk("t1_irq", 32'(o_irq), 32'h2);
        chk("t1_busy_clear", 32'(o_ch_busy), 32'd0);
        irq_clr = 4'b0010; cycle(); irq_clr = 4'b0000;
        chk("t1_irq_clr", 32'(o_irq), 32'd0);

        // Chain continuation.
        wr(0, 3, 32'h8000); wr(0, 4, 32'h0); wr(0, 2, 32'h10); wr(0, 5, 32'h0);
        idle(3);
        pulse_done(0);
        chk("t2_next_valid", 32'(o_next_valid), 32'd1);
        chk("t2_next_ch", 32'(o_next_ch), 32'd0);
        chk("t2_next_addr", o_next_addr, 32'h8000);
        chk("t2_irq", 32'(o_irq), 32'd0);
        cycle();
        chk("t2_next_one_cycle", 32'(o_next_valid), 32'd0);

        // Round-robin from a fresh pointer.
        rst_n = 1'b0; model_reset(); cycle(); rst_n = 1'b1;
        issue_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) wr(c, 2, 32'h100 + 32'(c));
        for (int c = 0; c < NUM_CH; c++) wr(c, 5, 32'h0);
        issue_ready = 1'b1;
        collect_grants(12, order, when);
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(k));
        for (int k = 1; k < when.size(); k++) chk("rr_gap", 32'(when[k] - when[k-1]), 32'd2);
        for (int c = 0; c < NUM_CH; c++) pulse_done(c);
        wr(2, 5, 32'h0); idle(3); pulse_done(2);
        issue_ready = 1'b0;
        wr(0, 5, 32'h0); wr(2, 5, 32'h0);
        issue_ready = 1'b1;
        collect_grants(8, order, when);
        chk("rr2_count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("rr2_first", 32'(order[0]), 32'd0);
            chk("rr2_second", 32'(order[1]), 32'd2);
        end
        pulse_done(0); pulse_done(2);

        // Cancel of an open offer.
        issue_ready = 1'b0;
        wr(2, 5, 32'h0); cycle();
        chk("cancel_offer", 32'(o_issue_valid), 32'd1);
        chk("cancel_offer_ch", 32'(o_issue_ch), 32'd2);
        dmaen = 4'b1011; cycle();
        chk("cancel_valid_drop", 32'(o_issue_valid), 32'd0);
        chk("cancel_busy", 32'(o_ch_busy), 32'd0);
        chk("cancel_irq", 32'(o_irq), 32'd0);
        dmaen = 4'hF;

        // Field write to an ACTIVE channel is dropped.
        wr(3, 0, 32'h3333);
        issue_ready = 1'b1;
        wr(3, 5, 32'h0); idle(2);
        wr(3, 0, 32'hDEAD);
        pulse_done(3);
        wr(3, 5, 32'h0); cycle();
        chk("active_write_ignored", o_issue_src, 32'h3333);
        idle(1); pulse_done(3);

        // Zero-length commit and same-cycle set/clear.
        wr(1, 2, 32'h0); wr(1, 4, 32'h1); wr(1, 5, 32'h0);
        chk("len0_irq", 32'(o_irq), 32'h2);
        chk("len0_no_issue", 32'(o_issue_valid), 32'd0);
        chk("len0_busy", 32'(o_ch_busy), 32'd0);
        irq_clr = 4'b0010; wr(1, 5, 32'h0); irq_clr = 4'b0000;
        chk("set_wins_clear", 32'(o_irq), 32'h2);
        irq_clr = 4'b0010; cycle(); irq_clr = 4'b0000;
        pulse_done(1);
        chk("done_idle_irq", 32'(o_irq), 32'd0);
        chk("done_idle_next", 32'(o_next_valid), 32'd0);

        // Asynchronous reset with one ACTIVE channel and an open offer.
        wr(1, 2, 32'h20); issue_ready = 1'b1; wr(1, 5, 32'h0); idle(2);
        issue_ready = 1'b0;
        wr(0, 5, 32'h0); cycle();
        chk("pre_reset_offer", 32'(o_issue_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(o_issue_valid), 32'd0);
        chk("async_rst_busy", 32'(o_ch_busy), 32'd0);
        chk("async_rst_irq", 32'(o_irq), 32'd0);
        chk("async_rst_next", 32'(o_next_valid), 32'd0);
        chk("async_rst_src", o_issue_src, 32'd0);
        cycle();
        rst_n = 1'b1;
        pulse_done(1);
        chk("post_rst_done_ignored", 32'(o_ch_busy | o_irq), 32'd0);
        wr(1, 2, 32'h5); issue_ready = 1'b1; wr(1, 5, 32'h0); cycle();
        chk("post_rst_src", o_issue_src, 32'd0);
        chk("post_rst_dst", o_issue_dst, 32'd0);
        chk("post_rst_len", o_issue_len, 32'h5);
        idle(1); pulse_done(1);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) dmaen[$urandom_range(0, 3)] ^= 1'b1;
            desc_we  = ($urandom_range(0, 2) == 0);
            desc_ch  = 2'($urandom_range(0, 3));
            desc_sel = ($urandom_range(0, 3) == 0) ? 4'd5 : 4'($urandom_range(0, 7));
            if (desc_sel == 4'd2) desc_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            else if (desc_sel == 4'd4) desc_wdata = 32'($urandom_range(0, 1));
            else desc_wdata = $urandom;
            issue_ready = 1'($urandom_range(0, 1));
            done    = ($urandom_range(0, 2) == 0) && !(desc_we && desc_sel == 4'd5);
            done_ch = 2'($urandom_range(0, 3));
            irq_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            cycle();
        end
        desc_we = 1'b0; done = 1'b0; irq_clr = 4'd0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
